// File: rtl/regfl_pkg.sv
// rtl/regfl_pkg.sv - shared opcodes, state encoding and default sizes for the 4x8 register file controller
package regfl_pkg;

  localparam int W_DEF = 8;
  localparam int A_DEF = 2;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_RSP  = 2'b11
  } state_e;

endpackage

// File: rtl/addr_cnt.sv
// rtl/addr_cnt.sv - loadable A-bit up-counter driving the register file read address
module addr_cnt
  import regfl_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [A-1:0] load_val,
  input  logic         inc,
  output logic [A-1:0] cnt
);

  // clear beats load beats increment
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfl_ctrl_4x8.sv
// rtl/regfl_ctrl_4x8.sv - command-driven write/read/dump initiator for the 4x8 register file
module regfl_ctrl_4x8
  import regfl_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [A-1:0] cmd_addr,
  input  logic [W-1:0] cmd_data,
  output logic         wr_e,
  output logic [A-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic [A-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [A-1:0] rsp_addr,
  output logic         rsp_last,
  output logic         busy
);

  state_e state, next_state;
  logic   dump;
  logic   cmd_fire;
  logic   rsp_fire;
  op_e    op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = (state == ST_RSP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (op)
            OP_WRITE: next_state = ST_WR;
            OP_READ:  next_state = ST_RD;
            OP_DUMP:  next_state = ST_RD;
            default:  next_state = ST_IDLE;
          endcase
        end
      end
      ST_WR:   next_state = ST_IDLE;
      ST_RD:   next_state = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) begin
          next_state = rsp_last ? ST_IDLE : ST_RD;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // a dump starts from address 0; the counter only advances on a non-final response
  addr_cnt #(.A(A)) u_addr_cnt (
    .clk      (clk),
    .clr      (rst),
    .load     (cmd_fire && (op == OP_READ || op == OP_DUMP)),
    .load_val ((op == OP_DUMP) ? '0 : cmd_addr),
    .inc      (rsp_fire && !rsp_last),
    .cnt      (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_e      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      dump      <= 1'b0;
    end else begin
      wr_e <= cmd_fire && (op == OP_WRITE);
      if (cmd_fire && op == OP_WRITE) begin
        wr_addr <= cmd_addr;
        wr_data <= cmd_data;
      end
      if (cmd_fire && op == OP_READ) begin
        dump <= 1'b0;
      end else if (cmd_fire && op == OP_DUMP) begin
        dump <= 1'b1;
      end
      if (state == ST_RD) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rd_data;
        rsp_addr  <= rd_addr;
        rsp_last  <= !dump || (&rd_addr);
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfl_ctrl_4x8.sv
// tb/tb_regfl_ctrl_4x8.sv - scoreboard bench for regfl_ctrl_4x8 with a behavioral register file
module tb_regfl_ctrl_4x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       wr_e;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_addr;
  logic       rsp_last;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic [1:0] addr;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [7:0] rf [4];

  always #5 clk = ~clk;

  regfl_ctrl_4x8 dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .wr_e      (wr_e),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always @(posedge clk) if (wr_e) rf[wr_addr] <= wr_data;
  assign rd_data = rf[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // responses are compared at the falling edge before the accepting rising edge
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_addr, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_addr", rsp_addr, e.addr);
        chk("rsp_last", rsp_last, e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                          output int waited);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    waited    = 0;
    while (!cmd_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("cmd_accept_timeout", waited, 0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("idle_timeout", n, 0);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] a, input logic l);
    exp_t e;
    e.data = d;
    e.addr = a;
    e.last = l;
    exp_q.push_back(e);
  endtask

  initial begin
    int w;
    logic [7:0] vals [4];
    vals[0] = 8'hA2; vals[1] = 8'h98; vals[2] = 8'h55; vals[3] = 8'hC7;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 8'h00;
    rsp_ready = 1'b1;

    // reset
    tick(); tick();
    chk("rst_wr_e", wr_e, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // write then read back
    send_cmd(2'b01, 2'd2, 8'h2E, w);
    chk("wr_e_pulse", wr_e, 1);
    chk("wr_addr", wr_addr, 2);
    chk("wr_data", wr_data, 8'h2E);
    chk("wr_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_e_drop", wr_e, 0);
    chk("wr_done_ready", cmd_ready, 1);
    push_exp(8'h2E, 2'd2, 1'b1);
    send_cmd(2'b10, 2'd2, 8'h00, w);
    chk("rd_valid_k", rsp_valid, 0);
    tick();
    chk("rd_valid_k1", rsp_valid, 1);
    tick();
    chk("rd_done_valid", rsp_valid, 0);
    chk("rd_done_busy", busy, 0);
    wait_idle();

    // fill and dump with backpressure on word 1
    for (int i = 0; i < 4; i++) begin
      send_cmd(2'b01, i[1:0], vals[i], w);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) push_exp(vals[i], i[1:0], i == 3);
    send_cmd(2'b11, 2'd0, 8'h00, w);
    tick();
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'h98);
      chk("stall_addr", rsp_addr, 1);
      chk("stall_last", rsp_last, 0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // command held while busy
    push_exp(8'hA2, 2'd0, 1'b1);
    push_exp(8'hC7, 2'd3, 1'b1);
    rsp_ready = 1'b0;
    send_cmd(2'b10, 2'd0, 8'h00, w);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_cmd_ready", cmd_ready, 0);
    end
    chk("busy_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    send_cmd(2'b10, 2'd3, 8'h00, w);
    chk("held_cmd_wait", w, 1);
    wait_idle();

    // NOP
    send_cmd(2'b00, 2'd1, 8'hFF, w);
    for (int i = 0; i < 2; i++) begin
      chk("nop_wr_e", wr_e, 0);
      chk("nop_rsp_valid", rsp_valid, 0);
      chk("nop_busy", busy, 0);
      tick();
    end

    // reset during the third dump word
    push_exp(8'hA2, 2'd0, 1'b0);
    push_exp(8'h98, 2'd1, 1'b0);
    send_cmd(2'b11, 2'd0, 8'h00, w);
    w = 0;
    while (!(rsp_valid && rsp_addr == 2'd1) && w < 50) begin
      tick();
      w++;
    end
    chk("dump_reach_word1", w < 50, 1);
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("word2_valid", rsp_valid, 1);
    chk("word2_addr", rsp_addr, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", rsp_valid, 0);
    end
    push_exp(8'h55, 2'd2, 1'b1);
    send_cmd(2'b10, 2'd2, 8'h00, w);
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
